// File: rtl/uart_pkg.sv
// Shared UART definitions.
//   BYTE_W             - width of one UART data byte
//   UART_RX_FIFO_DEPTH - default entry count of the receive FIFO
//   clog2_fn           - ceil(log2(value)), used to size FIFO pointers
package uart_pkg;

  localparam int BYTE_W             = 8;
  localparam int UART_RX_FIFO_DEPTH = 16;

  // Smallest w with 2**w >= value. Returns 0 for value <= 1.
  function automatic int clog2_fn(input int value);
    int w;
    w = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Byte storage for the receive FIFO.
// Ports:
//   clk    - write clock
//   we     - write enable; wdata is stored at waddr on the rising edge
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - combinational read of mem[raddr]
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_RX_FIFO_DEPTH,
  parameter int ADDR_W = clog2_fn(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [BYTE_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [BYTE_W-1:0] rdata
);

  logic [BYTE_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset; an entry is only read after it has been
  // written, and leaving it unreset lets it map onto plain RAM/register cells.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO sitting directly behind the UART receiver.
// Captures a byte on each one-cycle wr_en strobe and presents the oldest
// byte on a show-ahead valid/ready pop interface.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   wr_en      - push strobe (receiver data-received pulse)
//   wr_data    - byte to push
//   rd_valid   - head byte available
//   rd_data    - head byte (don't-care while empty)
//   rd_ready   - consumer accepts head; pop on rd_valid && rd_ready
//   count      - entries held, 0..DEPTH
//   full       - count == DEPTH
//   empty      - count == 0
//   overflow   - sticky: a push was dropped because the FIFO was full
//   ovf_clr    - clears overflow (a simultaneous drop wins)
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_RX_FIFO_DEPTH,
  parameter int ADDR_W = clog2_fn(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  output logic              rd_valid,
  output logic [BYTE_W-1:0] rd_data,
  input  logic              rd_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  input  logic              ovf_clr
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push;
  logic              pop;
  logic              drop;

  // Flags come straight from the registered count, so they add no latency.
  assign empty    = (count == '0);
  assign full     = (count == FULL_COUNT);
  assign rd_valid = !empty;

  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // only dropped when nothing leaves.
  assign pop  = rd_valid && rd_ready;
  assign push = wr_en && (!full || pop);
  assign drop = wr_en && full && !pop;

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values of push/pop regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers wrap naturally at ADDR_W bits since DEPTH is a power of two.
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (ADDR_W + 1)'(1);
        2'b01:   count <= count - (ADDR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Set has priority over clear so a drop coinciding with ovf_clr is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  uart_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

endmodule
